// File: rtl/pipe_stage_chain.sv
// In-order pipeline register chain: DEPTH stages with valid/ready handshake, bubble collapse,
// global stall and partial flush of the younger stages. Define PIPE_PERF_CNT_EN for perf counters.
module pipe_stage_chain #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 3,
    parameter int SW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clock,
    input  logic                       rst_l,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [SW-1:0]              flush_stage,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                stall_cycles,
    output logic [15:0]                flush_kills
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] kill;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH:0]   rdy;

    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            rdy[i] = ~v_q[i] | rdy[i+1];
        end
    end

    // flush_stage values beyond DEPTH-1 naturally kill every stage
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = flush && (i <= int'(flush_stage));
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d[0]    = 1'b0;
            data_d[0] = '0;
        end else if (!stall && rdy[0]) begin
            v_d[0]    = in_valid;
            data_d[0] = in_data;
        end
        // surviving stages keep moving during a flush and take a bubble from a killed neighbour
        for (int i = 1; i < DEPTH; i++) begin
            if (kill[i]) begin
                v_d[i]    = 1'b0;
                data_d[i] = '0;
            end else if ((flush || !stall) && rdy[i]) begin
                v_d[i]    = v_q[i-1] & ~kill[i-1];
                data_d[i] = kill[i-1] ? '0 : data_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            v_q       <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q       <= v_d;
            data_q    <= data_d;
            occupancy <= OW'($countones(v_d));
        end
    end

    assign out_valid = v_q[DEPTH-1] & ~stall & ~kill[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign in_ready  = rdy[0] & ~stall & ~flush;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] kills_q;
    logic [16:0] kills_sum;

    always_comb kills_sum = {1'b0, kills_q} + 17'($countones(v_q & kill));

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            stall_q <= '0;
            kills_q <= '0;
        end else begin
            if (v_q[DEPTH-1] && (stall || !out_ready) && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            kills_q <= kills_sum[16] ? 16'hFFFF : kills_sum[15:0];
        end
    end

    assign stall_cycles = stall_q;
    assign flush_kills  = kills_q;
`else
    assign stall_cycles = '0;
    assign flush_kills  = '0;
`endif

endmodule
